// File: rtl/dot_job_sequencer.sv
// Job scheduler for the dot-product memory controller.
// Accepts host jobs, then runs LOAD, COMPUTE and WRITE on the controller, one
// phase after another. Each phase gets a one-cycle reset pulse and a one-cycle
// start pulse, and the sequencer then follows that phase's busy flag under a
// watchdog. Completion or timeout is reported on the done handshake.
// Every output is a register or a copy of one, so no input reaches an output
// combinationally.
module dot_job_sequencer #(
  parameter int Tag_Width     = 4,
  parameter int Timeout_Width = 8,
  parameter int Ack_Timeout   = 4,
  parameter int Phase_Timeout = 64
) (
  input  logic                 clk,
  input  logic                 Sys_reset,
  input  logic                 Job_Valid,
  output logic                 Job_Ready,
  input  logic [Tag_Width-1:0] Job_Tag,
  input  logic [1:0]           Job_Mode,
  output logic                 Mem_Index_reset,
  output logic                 Comp_reset,
  output logic                 load_from_file,
  output logic                 Computing,
  output logic                 write_to_file,
  input  logic                 loading_signal,
  input  logic                 computing_signal,
  input  logic                 write_to_file_signal,
  output logic                 Done_Valid,
  input  logic                 Done_Ready,
  output logic [Tag_Width-1:0] Done_Tag,
  output logic                 Done_Error,
  output logic [1:0]           Done_Err_Phase,
  output logic                 Busy,
  output logic [7:0]           Jobs_Completed
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PH_RST    = 3'd1,
    PH_START  = 3'd2,
    WAIT_RISE = 3'd3,
    WAIT_FALL = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [1:0] PH_LOAD  = 2'd0;
  localparam logic [1:0] PH_COMP  = 2'd1;
  localparam logic [1:0] PH_WRITE = 2'd2;
  localparam logic [1:0] PH_NONE  = 2'd3;

  localparam logic [Timeout_Width-1:0] ACK_LIMIT   = Timeout_Width'(Ack_Timeout - 1);
  localparam logic [Timeout_Width-1:0] PHASE_LIMIT = Timeout_Width'(Phase_Timeout - 1);

  state_t                 state_q;
  logic [1:0]             phase_q;
  logic [Timeout_Width-1:0] wd_q;
  logic                   skip_write_q;
  logic [Tag_Width-1:0]   tag_q;
  logic [2:0]             start_q;      // one-hot start pulses: {write, compute, load}
  logic                   phase_busy;
  logic                   any_busy;
  logic                   accept;

  // Watchdog increment that sticks at all-ones instead of wrapping.
  function automatic logic [Timeout_Width-1:0] sat_inc(input logic [Timeout_Width-1:0] v);
    return (v == {Timeout_Width{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Start pulse belonging to a phase.
  function automatic logic [2:0] start_onehot(input logic [1:0] ph);
    logic [2:0] r;
    r = 3'b000;
    case (ph)
      PH_LOAD:  r = 3'b001;
      PH_COMP:  r = 3'b010;
      PH_WRITE: r = 3'b100;
      default:  r = 3'b000;
    endcase
    return r;
  endfunction

  assign any_busy        = loading_signal | computing_signal | write_to_file_signal;
  assign accept          = (state_q == IDLE) && Job_Valid && Job_Ready;
  assign load_from_file  = start_q[0];
  assign Computing       = start_q[1];
  assign write_to_file   = start_q[2];

  // Busy flag of the phase currently being tracked.
  always_comb begin
    phase_busy = 1'b0;
    case (phase_q)
      PH_LOAD:  phase_busy = loading_signal;
      PH_COMP:  phase_busy = computing_signal;
      PH_WRITE: phase_busy = write_to_file_signal;
      default:  phase_busy = 1'b0;
    endcase
  end

  // Job tag is payload only, so it is captured at acceptance without a reset.
  always_ff @(posedge clk) begin
    if (accept) tag_q <= Job_Tag;
  end

  // Sequencer FSM with registered pulse and completion outputs.
  always_ff @(posedge clk or posedge Sys_reset) begin
    if (Sys_reset) begin
      state_q         <= IDLE;
      phase_q         <= PH_LOAD;
      wd_q            <= '0;
      skip_write_q    <= 1'b0;
      start_q         <= 3'b000;
      Mem_Index_reset <= 1'b0;
      Comp_reset      <= 1'b0;
      Job_Ready       <= 1'b1;
      Busy            <= 1'b0;
      Done_Valid      <= 1'b0;
      Done_Tag        <= '0;
      Done_Error      <= 1'b0;
      Done_Err_Phase  <= PH_NONE;
      Jobs_Completed  <= 8'd0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      start_q         <= 3'b000;
      Mem_Index_reset <= 1'b0;
      Comp_reset      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            skip_write_q <= Job_Mode[1];
            Job_Ready    <= 1'b0;
            Busy         <= 1'b1;
            state_q      <= PH_RST;
            if (Job_Mode[0]) begin
              phase_q    <= PH_COMP;
              Comp_reset <= 1'b1;
            end else begin
              phase_q         <= PH_LOAD;
              Mem_Index_reset <= 1'b1;
            end
          end
        end
        PH_RST: begin
          state_q <= PH_START;
          if (!any_busy) start_q <= start_onehot(phase_q);
        end
        PH_START: begin
          // A start pulse is only raised once every busy flag has cleared.
          if (|start_q) begin
            state_q <= WAIT_RISE;
            wd_q    <= '0;
          end else if (!any_busy) begin
            start_q <= start_onehot(phase_q);
          end
        end
        WAIT_RISE: begin
          if (phase_busy) begin
            state_q <= WAIT_FALL;
            wd_q    <= '0;
          end else if (wd_q == ACK_LIMIT) begin
            state_q        <= DONE;
            Done_Valid     <= 1'b1;
            Done_Tag       <= tag_q;
            Done_Error     <= 1'b1;
            Done_Err_Phase <= phase_q;
          end else begin
            wd_q <= sat_inc(wd_q);
          end
        end
        WAIT_FALL: begin
          if (!phase_busy) begin
            if (phase_q == PH_LOAD) begin
              phase_q    <= PH_COMP;
              state_q    <= PH_RST;
              Comp_reset <= 1'b1;
            end else if (phase_q == PH_COMP && !skip_write_q) begin
              phase_q         <= PH_WRITE;
              state_q         <= PH_RST;
              Mem_Index_reset <= 1'b1;
            end else begin
              state_q        <= DONE;
              Done_Valid     <= 1'b1;
              Done_Tag       <= tag_q;
              Done_Error     <= 1'b0;
              Done_Err_Phase <= PH_NONE;
            end
          end else if (wd_q == PHASE_LIMIT) begin
            state_q        <= DONE;
            Done_Valid     <= 1'b1;
            Done_Tag       <= tag_q;
            Done_Error     <= 1'b1;
            Done_Err_Phase <= phase_q;
          end else begin
            wd_q <= sat_inc(wd_q);
          end
        end
        DONE: begin
          if (Done_Ready) begin
            state_q        <= IDLE;
            Done_Valid     <= 1'b0;
            Done_Tag       <= '0;
            Done_Error     <= 1'b0;
            Done_Err_Phase <= PH_NONE;
            Jobs_Completed <= Jobs_Completed + 8'd1;
            Job_Ready      <= 1'b1;
            Busy           <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dot_job_sequencer.md
Name: dot_job_sequencer

Overview:
- Top-level job scheduler for the dot-product memory controller. It accepts dot-product jobs from the host over a valid/ready handshake.
- For each job it runs the controller's three phases in order: LOAD, COMPUTE, WRITE. For each phase it issues the controller's index/step reset and start pulses, then tracks the controller's busy flags.
- It reports completion or a timeout error through a done valid/ready handshake.
- It sits between the host interface and the memory controller. It is the only driver of the controller's start and reset inputs.

Parameters:
- Tag_Width, 4, width of the job tag carried from request to completion.
- Timeout_Width, 8, width of the phase watchdog counter.
- Ack_Timeout, 4, maximum cycles in WAIT_RISE before the busy flag must rise.
- Phase_Timeout, 64, maximum cycles in WAIT_FALL before the busy flag must fall. Must be at least Total_Computation_Steps+2 and at least Ram_Depth+3.

Ports:
- clk  in  1  single clock, all state on rising edge.
- Sys_reset  in  1  reset, asynchronous, active-high; clears all state immediately.
- Job_Valid  in  1  host job request.
- Job_Ready  out  1  sequencer can accept a job.
- Job_Tag  in  Tag_Width  tag of the job.
- Job_Mode  in  2  bit0 = skip LOAD (operands already resident), bit1 = skip WRITE.
- Mem_Index_reset  out  1  one-cycle reset of the controller memory index (LOAD and WRITE phases).
- Comp_reset  out  1  one-cycle reset of the controller step counter (COMPUTE phase).
- load_from_file  out  1  one-cycle LOAD start pulse.
- Computing  out  1  one-cycle COMPUTE start pulse.
- write_to_file  out  1  one-cycle WRITE start pulse.
- loading_signal  in  1  controller LOAD busy.
- computing_signal  in  1  controller COMPUTE busy.
- write_to_file_signal  in  1  controller WRITE busy.
- Done_Valid  out  1  completion record valid.
- Done_Ready  in  1  host accepts the completion record.
- Done_Tag  out  Tag_Width  tag of the finished job.
- Done_Error  out  1  the job aborted on a timeout.
- Done_Err_Phase  out  2  phase that timed out: 0 LOAD, 1 COMPUTE, 2 WRITE; 3 when there is no error.
- Busy  out  1  a job is in flight (state is not IDLE).
- Jobs_Completed  out  8  count of completion handshakes, error-free and errored; wraps 255 to 0.

Behaviour:
- Reset values: state IDLE, phase LOAD, watchdog 0, and all outputs 0, except Job_Ready=1 and Done_Err_Phase=3. Reset mid-job aborts the job with no completion record, and all pulses drop the same instant.
- States: IDLE, PH_RST, PH_START, WAIT_RISE, WAIT_FALL, DONE. A 2-bit phase register holds the current phase.
- All outputs are decoded from registered state only; no combinational path from any input to any output.
- IDLE:
  - Job_Ready=1.
  - On Job_Valid&&Job_Ready: latch Job_Tag and Job_Mode, then go to PH_RST.
  - Phase becomes LOAD, or COMPUTE if bit0 is set.
- PH_RST (exactly one cycle): assert Comp_reset in COMPUTE, otherwise Mem_Index_reset.
- PH_START (exactly one cycle): assert the phase's start pulse. Clear the watchdog on exit.
- WAIT_RISE:
  - If the phase busy flag is 1, go to WAIT_FALL and clear the watchdog.
  - Else increment the watchdog. When watchdog==Ack_Timeout-1 and the flag is still 0, take the error path.
- WAIT_FALL:
  - If the busy flag is 0, advance the phase.
  - Else increment the watchdog. When watchdog==Phase_Timeout-1 and the flag is still 1, take the error path.
- Phase advance:
  - LOAD goes to COMPUTE.
  - COMPUTE goes to WRITE, or to DONE if bit1 is set.
  - WRITE goes to DONE.
  - Every next phase re-enters PH_RST.
  - COMPUTE is never skipped.
- Error path: go to DONE with Done_Error=1 and Done_Err_Phase set to the current phase. Remaining phases are not issued.
- DONE:
  - Done_Valid=1; Done_Tag, Done_Error and Done_Err_Phase are held stable.
  - On Done_Ready, increment Jobs_Completed, go to IDLE and clear the Done_* fields. Job_Ready rises the next cycle.
  - Done_Ready outside DONE is ignored.
- Timing: the minimum per-phase overhead between PH_RST and the first WAIT_RISE cycle is 2 cycles.
- Phase ordering: exactly one start pulse per phase. Never two start pulses in the same cycle. A start pulse is never issued while any busy flag is 1; if a flag is still set in PH_START, hold PH_START (pulse deasserted) until it clears.
- Job_Valid outside IDLE is ignored. Held tag/mode are not overwritten.
- Watchdog saturates; it never wraps.

Test Plan:
- Nominal job: tag=5, mode=0, stub busy flags high for 17 (LOAD), 20 (COMPUTE) and 18 (WRITE) cycles → pulses appear in order LOAD, COMPUTE, WRITE, each preceded by its one-cycle reset. Done_Valid rises with Done_Tag=5, Done_Error=0, Done_Err_Phase=3. Jobs_Completed=1 after Done_Ready.
- Mode=3 (skip LOAD and WRITE), tag=9 → only Comp_reset and Computing pulse; load_from_file and write_to_file stay 0 throughout; Done_Tag=9.
- computing_signal never rises → Done_Error=1 and Done_Err_Phase=1, reached 4 cycles after entering WAIT_RISE; write_to_file never pulses.
- loading_signal stuck at 1 → timeout after 64 WAIT_FALL cycles; Done_Err_Phase=0.
- Done backpressure: Done_Ready held 0 for 10 cycles with Job_Valid=1 → Done_* fields stable, Job_Ready=0. When Done_Ready=1, Job_Ready rises the following cycle and the new job is accepted.
- Sys_reset asserted in COMPUTE WAIT_FALL → all outputs 0 and Job_Ready=1 asynchronously, no Done_Valid, Jobs_Completed=0; the next job runs normally.
